// File: rtl/multi_debounce_unit.sv
// multi_debounce_unit
// Multi-channel debouncer for active-low push-buttons. Each channel runs a
// synchroniser, a stability counter and a four-state qualification FSM.
// Qualified presses become sticky pending events. The consumer drains them
// one at a time, lowest channel index first, through a valid/acknowledge
// handshake.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | button released and stable, waiting for a low sample
// ST_ARMING    | low seen, counting consecutive low samples toward a press
// ST_PRESSED   | press qualified, debounced level high
// ST_RELEASING | high seen while pressed, counting toward a release
module multi_debounce_unit #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_WIDTH     = 20,
    parameter int SYNC_STAGES   = 2,
    parameter int ID_WIDTH      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] buttonNotPressed,
    input  logic                acknowledge,
    output logic                event_valid,
    output logic [ID_WIDTH-1:0] event_id,
    output logic [CHANNELS-1:0] debounce,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overrun
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    // Terminal count of the stability counter.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    // Reject parameter sets that cannot work.
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("multi_debounce_unit: CHANNELS must be in 1..32");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("multi_debounce_unit: STABLE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("multi_debounce_unit: SYNC_STAGES must be >= 2");
    end
    if ((64'd1 << CNT_WIDTH) < 64'(STABLE_CYCLES)) begin : g_bad_cnt_width
        $error("multi_debounce_unit: CNT_WIDTH too narrow for STABLE_CYCLES");
    end
    if (ID_WIDTH < 1 || (CHANNELS > 1 && (64'd1 << ID_WIDTH) < 64'(CHANNELS))) begin : g_bad_id_width
        $error("multi_debounce_unit: ID_WIDTH cannot encode every channel");
    end

    // ------------------------------------------------------------------
    // Synchroniser: reset to released so nothing qualifies out of reset.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] btn_s;

    // Shift raw buttons through SYNC_STAGES flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '1;
            end
        end else begin
            sync_q[0] <= buttonNotPressed;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-channel qualification FSM and stability counter.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] qual_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        state_t               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 deb_q, deb_d;
        logic                 qual;

        // State, counter and debounced level registers.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                deb_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                deb_q   <= deb_d;
            end
        end

        // Next state, counter update and press-qualified strobe.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            qual    = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!btn_s[i]) begin
                        state_d = ST_ARMING;
                        cnt_d   = '0;
                    end
                end
                ST_ARMING: begin
                    if (btn_s[i]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                        qual    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                ST_PRESSED: begin
                    if (btn_s[i]) begin
                        state_d = ST_RELEASING;
                        cnt_d   = '0;
                    end
                end
                ST_RELEASING: begin
                    if (!btn_s[i]) begin
                        // Release bounce: back to pressed, no new event.
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            // Debounced level follows the next state so the flop tracks state_q exactly.
            deb_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASING);
        end

        assign qual_vec[i] = qual;
        assign debounce[i] = deb_q;
    end

    // ------------------------------------------------------------------
    // Event queue, arbitration and handshake.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] overrun_q, overrun_d;
    logic [CHANNELS-1:0] clr_vec;

    // Lowest-index pending channel wins; id is 0 when nothing is pending.
    always_comb begin
        event_id = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                event_id = ID_WIDTH'(k);
            end
        end
    end

    assign event_valid = |pending_q;

    // Acknowledged channel clears; new presses set; a press onto an
    // uncleared pending bit flags overrun.
    always_comb begin
        clr_vec = '0;
        if (acknowledge && event_valid) begin
            clr_vec = CHANNELS'(1) << event_id;
        end
        pending_d = (pending_q & ~clr_vec) | qual_vec;
        overrun_d = (overrun_q & ~clr_vec) | (qual_vec & pending_q & ~clr_vec);
    end

    // Pending and overrun registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_multi_debounce_unit.sv
// tb_multi_debounce_unit
// Directed bench for multi_debounce_unit with CHANNELS=4, STABLE_CYCLES=4,
// SYNC_STAGES=2. A press driven just after an edge is qualified at the
// seventh following edge.
module tb_multi_debounce_unit;

    logic       clock;
    logic       reset_n;
    logic [3:0] buttonNotPressed;
    logic       acknowledge;
    logic       event_valid;
    logic [1:0] event_id;
    logic [3:0] debounce;
    logic [3:0] pending;
    logic [3:0] overrun;

    int checks = 0;
    int errors = 0;

    multi_debounce_unit #(
        .CHANNELS     (4),
        .STABLE_CYCLES(4),
        .CNT_WIDTH    (20),
        .SYNC_STAGES  (2)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .buttonNotPressed(buttonNotPressed),
        .acknowledge     (acknowledge),
        .event_valid     (event_valid),
        .event_id        (event_id),
        .debounce        (debounce),
        .pending         (pending),
        .overrun         (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges, ending 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ack_pulse();
        acknowledge = 1'b1;
        tick(1);
        acknowledge = 1'b0;
    endtask

    initial begin
        reset_n          = 1'b0;
        acknowledge      = 1'b0;
        buttonNotPressed = 4'($urandom);

        // 1. Reset with random inputs.
        tick(1);
        buttonNotPressed = 4'($urandom);
        tick(2);
        chk("rst_debounce", 32'(debounce), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_valid", 32'(event_valid), 32'h0);
        chk("rst_id", 32'(event_id), 32'h0);
        buttonNotPressed = 4'b1111;
        tick(3);
        reset_n = 1'b1;

        // Reset in the middle of ARMING, button held low through it.
        buttonNotPressed = 4'b1110;
        tick(4);
        reset_n = 1'b0;
        #1;
        chk("midarm_pending", 32'(pending), 32'h0);
        chk("midarm_debounce", 32'(debounce), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        chk("requal_early_pending", 32'(pending), 32'h0);
        chk("requal_early_debounce", 32'(debounce), 32'h0);
        tick(1);
        chk("requal_pending", 32'(pending), 32'h1);
        chk("requal_debounce", 32'(debounce), 32'h1);
        chk("requal_valid", 32'(event_valid), 32'h1);
        chk("requal_id", 32'(event_id), 32'h0);
        ack_pulse();
        chk("requal_ack_pending", 32'(pending), 32'h0);
        chk("requal_ack_valid", 32'(event_valid), 32'h0);
        chk("requal_ack_debounce", 32'(debounce), 32'h1);
        buttonNotPressed = 4'b1111;
        tick(6);
        chk("rel0_early_debounce", 32'(debounce), 32'h1);
        tick(1);
        chk("rel0_debounce", 32'(debounce), 32'h0);

        // 2. Clean press on channel 2.
        buttonNotPressed = 4'b1011;
        tick(6);
        chk("ch2_early_pending", 32'(pending), 32'h0);
        chk("ch2_early_debounce", 32'(debounce), 32'h0);
        tick(1);
        chk("ch2_pending", 32'(pending), 32'h4);
        chk("ch2_debounce", 32'(debounce), 32'h4);
        chk("ch2_valid", 32'(event_valid), 32'h1);
        chk("ch2_id", 32'(event_id), 32'h2);
        ack_pulse();
        chk("ch2_ack_pending", 32'(pending), 32'h0);
        chk("ch2_ack_valid", 32'(event_valid), 32'h0);
        chk("ch2_ack_debounce", 32'(debounce), 32'h4);
        ack_pulse();
        chk("idle_ack_pending", 32'(pending), 32'h0);
        chk("idle_ack_overrun", 32'(overrun), 32'h0);
        buttonNotPressed = 4'b1111;
        tick(8);
        chk("ch2_rel_debounce", 32'(debounce), 32'h0);

        // 3. Glitches on channel 0: low 3, high 1, low 3.
        buttonNotPressed = 4'b1110;
        tick(3);
        buttonNotPressed = 4'b1111;
        tick(1);
        buttonNotPressed = 4'b1110;
        tick(3);
        chk("glitch_mid_debounce", 32'(debounce), 32'h0);
        buttonNotPressed = 4'b1111;
        tick(10);
        chk("glitch_pending", 32'(pending), 32'h0);
        chk("glitch_debounce", 32'(debounce), 32'h0);

        // Release bounce on held channel 1.
        buttonNotPressed = 4'b1101;
        tick(7);
        chk("ch1_pending", 32'(pending), 32'h2);
        chk("ch1_debounce", 32'(debounce), 32'h2);
        ack_pulse();
        chk("ch1_ack_pending", 32'(pending), 32'h0);
        buttonNotPressed = 4'b1111;
        tick(2);
        buttonNotPressed = 4'b1101;
        tick(10);
        chk("bounce_debounce", 32'(debounce), 32'h2);
        chk("bounce_pending", 32'(pending), 32'h0);
        buttonNotPressed = 4'b1111;
        tick(8);
        chk("ch1_rel_debounce", 32'(debounce), 32'h0);

        // 4. Channels 3 and 1 qualify on the same edge.
        buttonNotPressed = 4'b0101;
        tick(7);
        chk("prio_pending", 32'(pending), 32'ha);
        chk("prio_id", 32'(event_id), 32'h1);
        chk("prio_debounce", 32'(debounce), 32'ha);
        acknowledge = 1'b1;
        tick(1);
        chk("prio_first_pending", 32'(pending), 32'h8);
        chk("prio_first_id", 32'(event_id), 32'h3);
        tick(1);
        acknowledge = 1'b0;
        chk("prio_drain_pending", 32'(pending), 32'h0);
        chk("prio_drain_valid", 32'(event_valid), 32'h0);
        chk("prio_drain_id", 32'(event_id), 32'h0);
        buttonNotPressed = 4'b1111;
        tick(8);

        // 5. Overrun on channel 0.
        buttonNotPressed = 4'b1110;
        tick(7);
        chk("ovr_first_pending", 32'(pending), 32'h1);
        chk("ovr_first_overrun", 32'(overrun), 32'h0);
        buttonNotPressed = 4'b1111;
        tick(8);
        buttonNotPressed = 4'b1110;
        tick(7);
        chk("ovr_pending", 32'(pending), 32'h1);
        chk("ovr_overrun", 32'(overrun), 32'h1);
        ack_pulse();
        chk("ovr_ack_pending", 32'(pending), 32'h0);
        chk("ovr_ack_overrun", 32'(overrun), 32'h0);
        buttonNotPressed = 4'b1111;
        tick(8);

        // 6. Acknowledge channel 2 on the edge its second press qualifies.
        buttonNotPressed = 4'b1011;
        tick(7);
        chk("coll_first_pending", 32'(pending), 32'h4);
        buttonNotPressed = 4'b1111;
        tick(8);
        buttonNotPressed = 4'b1011;
        tick(6);
        acknowledge = 1'b1;
        tick(1);
        acknowledge = 1'b0;
        chk("coll_pending", 32'(pending), 32'h4);
        chk("coll_overrun", 32'(overrun), 32'h0);
        chk("coll_valid", 32'(event_valid), 32'h1);
        ack_pulse();
        chk("coll_ack_pending", 32'(pending), 32'h0);
        chk("coll_ack_valid", 32'(event_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
